// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/ready channel between the fetch unit (master) and imem (slave).
interface if_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        rdy;
    logic [31:0] rdata;

    modport master (output req, addr, input  rdy, rdata);
    modport slave  (input  req, addr, output rdy, rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, handshakes with imem and feeds the IF/ID register.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INS  = 32'h2000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [31:0]           redirect_pc,
    if_fetch_unit_if.master       imem,
    output logic [31:0]           pc,
    output logic [31:0]           IF_ins,
    output logic [31:0]           IF_pc_plus_4,
    output logic                  IF_valid
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

    state_t            state, state_n;
    logic [XLEN-1:0]   pc_n, tgt, tgt_n, buf_ins, buf_ins_n;
    logic [XLEN-1:0]   ins_n, pc4_n;
    logic              valid_n;
    logic [XLEN-1:0]   pc_plus_4, redir_aligned;

    assign pc_plus_4     = pc + XLEN'(4);
    assign redir_aligned = {redirect_pc[XLEN-1:2], 2'b00};

    // pc only moves on completion, so in DRAIN it still holds the stale request address
    assign imem.req  = (state != HOLD);
    assign imem.addr = pc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            tgt          <= '0;
            buf_ins      <= NOP_INS;
            IF_ins       <= NOP_INS;
            IF_pc_plus_4 <= '0;
            IF_valid     <= 1'b0;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            tgt          <= tgt_n;
            buf_ins      <= buf_ins_n;
            IF_ins       <= ins_n;
            IF_pc_plus_4 <= pc4_n;
            IF_valid     <= valid_n;
        end
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        tgt_n     = tgt;
        buf_ins_n = buf_ins;
        ins_n     = IF_ins;
        pc4_n     = IF_pc_plus_4;
        valid_n   = 1'b0;
        case (state)
            FETCH: begin
                if (imem.rdy) begin
                    if (redirect) begin
                        pc_n = redir_aligned;
                    end else if (stall) begin
                        buf_ins_n = imem.rdata;
                        pc_n      = pc_plus_4;
                        state_n   = HOLD;
                    end else begin
                        ins_n   = imem.rdata;
                        pc4_n   = pc_plus_4;
                        valid_n = 1'b1;
                        pc_n    = pc_plus_4;
                    end
                end else if (redirect) begin
                    tgt_n   = redir_aligned;
                    state_n = DRAIN;
                end
            end
            // pc already advanced past the buffered word, so it is that word's pc+4
            HOLD: begin
                if (redirect) begin
                    pc_n    = redir_aligned;
                    state_n = FETCH;
                end else if (!stall) begin
                    ins_n   = buf_ins;
                    pc4_n   = pc;
                    valid_n = 1'b1;
                    state_n = FETCH;
                end
            end
            DRAIN: begin
                if (redirect) tgt_n = redir_aligned;
                if (imem.rdy) begin
                    pc_n    = redirect ? redir_aligned : tgt;
                    state_n = FETCH;
                end
            end
            default: state_n = FETCH;
        endcase
    end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch front end. Owns the PC and runs a request/ready handshake with instruction memory.
- Produces the instruction word, PC+4 and a one-cycle valid/enable that the IF/ID pipeline register consumes.
- Sits upstream of IF/ID. Takes stall from the hazard unit and redirect (branch/jump target) from ID/EX.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INS, 32'h2000_0000, instruction word presented when nothing valid has been fetched (addi $0,$0,0).

Ports:
- clk, input, 1, single clock; all state updates on posedge.
- rst, input, 1, synchronous, active-low reset; sampled on posedge clk.
- stall, input, 1, hazard unit: IF/ID cannot accept a new instruction this cycle.
- redirect, input, 1, ID/EX: discard current fetch stream and fetch from redirect_pc.
- redirect_pc, input, 32, redirect target; word aligned.
- imem_req, output, 1, instruction memory request.
- imem_addr, output, 32, fetch address; stable while imem_req=1 until accepted.
- imem_rdy, input, 1, memory completes the request this cycle; imem_rdata valid in that cycle.
- imem_rdata, input, 32, fetched instruction word.
- pc, output, 32, current fetch PC.
- IF_ins, output, 32, instruction to IF/ID; registered.
- IF_pc_plus_4, output, 32, address of IF_ins plus 4; registered.
- IF_valid, output, 1, one-cycle pulse; drives the IF/ID enable.

Behaviour:
- Reset (rst=0 at posedge): pc=RESET_PC, state=FETCH, IF_ins=NOP_INS, IF_pc_plus_4=0, IF_valid=0, redirect target register=0.
- Reset dominates everything, including an in-flight memory request. The bench memory model is reset alongside.
- Priority when not in reset: redirect > stall.
- States: FETCH, HOLD, DRAIN.
- imem_req=1 in FETCH and DRAIN, 0 in HOLD.
- imem_addr=pc in FETCH; the stale request address in DRAIN.
- FETCH, imem_rdy=0, redirect=0: hold state and address.
- FETCH, imem_rdy=0, redirect=1: save redirect_pc, go DRAIN. The request cannot be abandoned.
- FETCH, imem_rdy=1, redirect=1: discard rdata, pc<=redirect_pc, stay FETCH, IF_valid=0.
- FETCH, imem_rdy=1, stall=0: IF_ins<=imem_rdata, IF_pc_plus_4<=pc+4, IF_valid<=1 next cycle, pc<=pc+4, stay FETCH. Zero-wait memory gives one instruction per cycle.
- FETCH, imem_rdy=1, stall=1: buffer rdata and pc+4 internally, pc<=pc+4, go HOLD, IF_valid=0.
- HOLD, redirect=1: drop buffer, pc<=redirect_pc, go FETCH.
- HOLD, stall=1: remain in HOLD; IF outputs unchanged.
- HOLD, stall=0: IF_ins/IF_pc_plus_4 <= buffer, IF_valid<=1, go FETCH. The new request for pc issues that same cycle.
- DRAIN, redirect=1: overwrite the saved target; the latest target wins.
- DRAIN, imem_rdy=1: discard rdata, pc<=saved target (or redirect_pc if redirect is asserted this cycle), go FETCH.
- IF_valid is high for exactly one cycle per delivered instruction. It is never high in the cycle after a discarded response.
- IF_ins and IF_pc_plus_4 retain their last value while IF_valid=0.
- Arithmetic: pc+4 is 32-bit modulo; 32'hFFFF_FFFC+4=0. Low two pc bits are always 0.
- Stall in FETCH before rdy has no effect; it is only evaluated at the completion edge.

Test Plan:
- Reset then zero-wait memory returning mem[a]=a|32'hA5: IF_valid pulses every cycle; IF_pc_plus_4=4,8,12; IF_ins=mem[0],mem[4],mem[8]. Before the first valid, IF_ins=32'h2000_0000.
- Memory with 2 wait cycles: imem_addr stable 3 cycles per fetch; IF_valid one pulse per 3 cycles; no duplicate or skipped addresses.
- stall=1 for 4 cycles over the completion of fetch 0x10:
  - imem_req=0 during HOLD; IF_valid=0.
  - On release, IF_ins=mem[0x10], IF_pc_plus_4=0x14, then fetch 0x14.
- redirect to 0x400 while the 0x20 fetch is waiting:
  - imem_addr stays 0x20 until rdy; that data is never presented.
  - Next address is 0x400; the next IF_pc_plus_4 is 0x404.
  - Second redirect to 0x800 during DRAIN yields next address 0x800.
- redirect and imem_rdy coincide, also with stall=1: rdata discarded, IF_valid=0, next address is redirect_pc.
- Mid-run checks:
  - rst=0 during DRAIN: next cycle pc=RESET_PC, IF_valid=0, IF_ins=32'h2000_0000.
  - pc=0xFFFF_FFFC fetch: IF_pc_plus_4=0, next address 0.
